sram_dumper: RTL
================

# sram_dumper

Read-side counterpart of the byte-lane SRAM preload path. On a start pulse it reads a range of 32-bit words from the four 8-bit SRAM banks (512 words × 4 lanes) and emits them as a little-endian byte stream over a valid/ready handshake, e.g. into the UART transmitter for memory readback. It sits between the imem/dmem bank muxes and a byte sink, and owns the bank port only while `busy`.

## Interface
Parameters:
- `ADDR_W`, 9, word address width per bank
- `DEPTH`, 512, words per bank
- `LANES`, 4, byte lanes (banks) per word

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  one-cycle request; ignored while `busy`
- `start_addr`  in  ADDR_W  first word address
- `word_count`  in  ADDR_W+1  words to dump (0..512)
- `CEN`  out  1 × LANES  per-bank chip enable, active-low
- `GWEN`  out  1 × LANES  per-bank global write enable, active-low
- `WEN`  out  8 × LANES  per-bank bit write enables, active-low
- `A`  out  ADDR_W × LANES  per-bank address
- `D`  out  8 × LANES  per-bank write data
- `Q`  in  8 × LANES  per-bank read data, valid the cycle after a CEN-low read
- `out_valid`  out  1  byte available
- `out_data`  out  8  byte value
- `out_ready`  in  1  sink accepts byte
- `busy`  out  1  dump in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RD, CAP, TX, FIN.
- IDLE: `start`=1 latches `start_addr` into `addr` and `word_count` into `remaining`. Then `remaining`==0 → FIN, else → RD.
- RD: all banks `CEN`=0, `GWEN`=1, `WEN`=8'hFF, `A`=`addr`. → CAP.
- CAP: latch `{Q[3],Q[2],Q[1],Q[0]}` into `word`; `lane`=0. → TX.
- TX: `out_valid`=1, `out_data`=`word[8*lane +: 8]`. On `out_valid && out_ready`: if `lane`==3, then `addr`=`addr`+1 mod DEPTH and `remaining`-1. If the result is 0 → FIN, else → RD. Otherwise `lane`+1.
- FIN: `done`=1 for one cycle → IDLE.
- Bank outputs outside RD: `CEN`=1, `GWEN`=1, `WEN`=8'hFF, `A`=0, `D`=0. The block never writes.
- `busy`=1 in every state except IDLE.
- Address wraps: 511 + 1 → 0. `word_count` > 512 is clamped to 512.
- `out_data` is stable and `out_valid` is never withdrawn until the byte is accepted.
- `rst` in any state → IDLE next cycle, and the sink sees no further bytes. A partial word is dropped.

## Timing
- Reset values: `CEN`=1, `GWEN`=1, `WEN`=8'hFF, `A`=0, `D`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- `start` at cycle 0 → RD at cycle 1 (CEN low) → CAP at cycle 2 → first `out_valid` at cycle 3.
- With `out_ready` held at 1: 6 cycles per word (RD, CAP, 4×TX). N words finish with `done` at cycle 6N+1.
- `word_count`=0: `done` pulses at cycle 1; banks are untouched and no bytes are emitted.
- `start` while `busy` or on the `done` cycle: ignored. The next `start` is accepted the cycle after FIN.
- `out_ready` stalls only hold TX. The bank is idle during stalls, and `Q` is not needed after CAP.

## Structure
- Shared package `sram_pkg`: `LANES`, `ADDR_W`, `DEPTH`, and the `dump_state_t` enum. The bank-idle constants (`CEN`/`GWEN`=1, `WEN`=8'hFF) also go here for reuse by the preload mux.
- Sub-module `word_serializer`: takes a 32-bit word with a load strobe and emits 4 bytes LSB-first over valid/ready, with a last-byte flag. The FSM instantiates it for the TX state.

## Test plan
- Preload banks with word k = 32'hA0B0C000+k; `start_addr`=0, `word_count`=2, `out_ready`=1. Expect bytes 00,C0,B0,A0,01,C0,B0,A0; `done` at cycle 13.
- `start_addr`=511, `word_count`=2. Expect words 511 then 0, with `A` sequence 511, 0 on RD cycles.
- `word_count`=0. Expect `done` at cycle 1, `CEN` stays all-1, and `out_valid` is never asserted.
- Random `out_ready` with 30% duty over 8 words. Expect a byte stream identical to the `out_ready`=1 run, and `out_data` constant while `out_valid && !out_ready`.
- `rst` asserted at the second TX cycle of word 0. Expect IDLE next cycle, all outputs at reset values, and a subsequent `start` to dump correctly from its `start_addr`.
- `start` pulsed again while `busy`. Expect no effect on `addr`, `remaining` or the byte stream.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the byte-lane SRAM preload/readback paths.
package sram_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned BYTE_W = 8;

    // Bank port values that leave an SRAM bank untouched
    localparam logic              BANK_CEN_IDLE  = 1'b1;
    localparam logic              BANK_GWEN_IDLE = 1'b1;
    localparam logic [BYTE_W-1:0] BANK_WEN_IDLE  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        TX,
        FIN
    } dump_state_t;

endpackage

// File: rtl/word_serializer.sv
// Emits a loaded word as LANES bytes, LSB first, over a valid/ready handshake.
module word_serializer #(
    parameter int unsigned LANES = sram_pkg::LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [8*LANES-1:0]     word,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   last_c
);
    import sram_pkg::*;

    localparam int unsigned WORD_W = 8 * LANES;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WORD_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              valid_q, valid_d;
    logic [BYTE_W-1:0] data_q, data_d;

    // Byte data is re-registered on each advance so it stays stable while stalled
    always_comb begin
        word_d  = word_q;
        lane_d  = lane_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            word_d  = word;
            lane_d  = '0;
            valid_d = 1'b1;
            data_d  = word[BYTE_W-1:0];
        end else if (valid_q && out_ready) begin
            if (lane_q == LANE_W'(LANES - 1)) begin
                valid_d = 1'b0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                data_d = BYTE_W'(word_q >> (BYTE_W * lane_d));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            word_q  <= word_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign last_c    = valid_q && (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/sram_dumper.sv
// Reads a word range from the byte-lane SRAM banks and streams it out little-endian.
module sram_dumper #(
    parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
    parameter int unsigned DEPTH  = sram_pkg::DEPTH,
    parameter int unsigned LANES  = sram_pkg::LANES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W:0]          word_count,
    output logic [LANES-1:0]         CEN,
    output logic [LANES-1:0]         GWEN,
    output logic [8*LANES-1:0]       WEN,
    output logic [ADDR_W*LANES-1:0]  A,
    output logic [8*LANES-1:0]       D,
    input  logic [8*LANES-1:0]       Q,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    import sram_pkg::*;

    localparam int unsigned CNT_W = ADDR_W + 1;

    dump_state_t              state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [CNT_W-1:0]         remaining_q, remaining_d;
    logic [LANES-1:0]         cen_q, cen_d;
    logic [ADDR_W*LANES-1:0]  a_q, a_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     ser_load_c;
    logic                     ser_last_c;
    logic [CNT_W-1:0]         count_clamped_c;
    logic [ADDR_W-1:0]        addr_inc_c;

    assign count_clamped_c = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
    assign addr_inc_c      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        ser_load_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = count_clamped_c;
                    state_d     = (count_clamped_c == '0) ? FIN : RD;
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                ser_load_c = 1'b1;
                state_d    = TX;
            end
            TX: begin
                // Word boundary: advance the address when the last byte is taken
                if (ser_last_c && out_ready) begin
                    addr_d      = addr_inc_c;
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? FIN : RD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bank and status outputs are registered against the upcoming state
        cen_d  = (state_d == RD) ? {LANES{~BANK_CEN_IDLE}} : {LANES{BANK_CEN_IDLE}};
        a_d    = (state_d == RD) ? {LANES{addr_d}} : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            cen_q       <= {LANES{BANK_CEN_IDLE}};
            a_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cen_q       <= cen_d;
            a_q         <= a_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    word_serializer #(
        .LANES (LANES)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load_c),
        .word      (Q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .last_c    (ser_last_c)
    );

    assign CEN  = cen_q;
    assign A    = a_q;
    assign GWEN = {LANES{BANK_GWEN_IDLE}};
    assign WEN  = {LANES{BANK_WEN_IDLE}};
    assign D    = '0;
    assign busy = busy_q;
    assign done = done_q;

endmodule
